hf_cmd_rx: RTL and testbench

- Receives 16-bit command frames from the ARM over SPI (spck/mosi/ncs) by oversampling them in the 13.56 MHz domain.
- Decodes each frame into the HF configuration word and the trace-enable bit.
- Feeds the HF top-level major-mode muxes and sub-modules directly; it is the stage immediately upstream of them.
- On a major-mode change, holds the effective major mode at OFF for a quiet gap so two mode modules never drive the coil or SSP pins back-to-back without a gap.

---
 rtl/hf_cmd_rx_pkg.sv | 29 ++
 rtl/hf_cmd_rx_sync_edge.sv | 25 ++
 rtl/hf_cmd_rx.sv | 193 +++++++++++++++++++
 tb/tb_hf_cmd_rx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hf_cmd_rx_pkg.sv
// rtl/hf_cmd_rx_pkg.sv - shared FPGA command codes, reset word and receiver state type
package hf_cmd_rx_pkg;

   // Command codes carried in frame bits [15:12]; shared with the ARM-side headers.
   localparam logic [3:0] FPGA_CMD_SET_CONFREG  = 4'h1;
   localparam logic [3:0] FPGA_CMD_TRACE_ENABLE = 4'h2;

   // Major mode that leaves the coil and SSP pins undriven.
   localparam logic [2:0] FPGA_MAJOR_MODE_OFF   = 3'd7;

   // Configuration word after reset: major mode OFF, everything else zero.
   localparam logic [8:0] FPGA_CONF_WORD_RESET  = 9'h1C0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DECODE,
      ST_QUIET,
      ST_APPLY
   } rx_state_t;

   // A quiet gap is only needed when handing over between two real (non-OFF) modes.
   function automatic logic needs_quiet(input logic [2:0] old_mode, input logic [2:0] new_mode);
      return (old_mode != new_mode) &&
             (old_mode != FPGA_MAJOR_MODE_OFF) &&
             (new_mode != FPGA_MAJOR_MODE_OFF);
   endfunction

endpackage

// File: rtl/hf_cmd_rx_sync_edge.sv
// rtl/hf_cmd_rx_sync_edge.sv - multi-stage synchroniser with rise/fall detect
module hf_cmd_rx_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   // Synchroniser chain plus one delayed copy for edge detection; deliberately not reset.
   always_ff @(posedge clk) begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
   end

   assign q    = chain[STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/hf_cmd_rx.sv
// rtl/hf_cmd_rx.sv - SPI command frame receiver and HF configuration register
module hf_cmd_rx
   import hf_cmd_rx_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int QUIET_CYCLES = 16,
   parameter int FRAME_BITS   = 16
) (
   input  logic       ck_1356meg,
   input  logic       reset,
   input  logic       spck,
   input  logic       mosi,
   input  logic       ncs,
   output logic [8:0] conf_word,
   output logic [2:0] major_mode,
   output logic [3:0] minor_mode,
   output logic [1:0] subcarrier_frequency,
   output logic       trace_enable,
   output logic       cfg_strobe,
   output logic       frame_err,
   output logic       busy
);

   localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

   rx_state_t state, next_state;

   logic spck_q, spck_rise, spck_fall;
   logic ncs_q, ncs_rise, ncs_fall;
   logic mosi_q, mosi_rise, mosi_fall;
   logic unused_edges;

   logic [15:0]   shift_reg;
   logic [4:0]    count;
   logic          in_frame;
   logic          pending;
   logic [QW-1:0] qcnt;

   logic accept_fall, reject_fall, frame_end, done_now;
   logic in_frame_next, pending_next, busy_next;
   logic is_conf, is_trace, frame_ok;
   logic consume, commit_conf, commit_trace, enter_quiet, apply_now, decode_err;

   hf_cmd_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_spck (
      .clk(ck_1356meg), .d(spck), .q(spck_q), .rise(spck_rise), .fall(spck_fall)
   );

   hf_cmd_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ncs (
      .clk(ck_1356meg), .d(ncs), .q(ncs_q), .rise(ncs_rise), .fall(ncs_fall)
   );

   hf_cmd_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(ck_1356meg), .d(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
   );

   // Only spck rising edges and both ncs edges carry meaning.
   assign unused_edges = ^{spck_q, spck_fall, mosi_rise, mosi_fall};

   // Capture runs independently of the FSM so a frame can arrive during a quiet gap.
   // A new frame is refused only while a completed frame is still waiting for decode.
   assign accept_fall   = ncs_fall & ~pending;
   assign reject_fall   = ncs_fall & pending;
   assign frame_end     = ncs_rise & in_frame;
   assign done_now      = pending | frame_end;
   assign in_frame_next = (in_frame | accept_fall) & ~frame_end;
   assign pending_next  = (pending | frame_end) & ~consume;

   assign is_conf  = (shift_reg[15:12] == FPGA_CMD_SET_CONFREG);
   assign is_trace = (shift_reg[15:12] == FPGA_CMD_TRACE_ENABLE);
   assign frame_ok = (count == 5'(FRAME_BITS)) && (is_conf || is_trace);

   assign busy_next = (next_state == ST_SHIFT) || (next_state == ST_DECODE) ||
                      (next_state == ST_QUIET) || in_frame_next || pending_next;

   assign minor_mode           = conf_word[3:0];
   assign subcarrier_frequency = conf_word[5:4];

   // FSM state register.
   always_ff @(posedge ck_1356meg) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Next-state decode and one-cycle control strobes for the datapath.
   always_comb begin
      next_state   = state;
      consume      = 1'b0;
      commit_conf  = 1'b0;
      commit_trace = 1'b0;
      enter_quiet  = 1'b0;
      apply_now    = 1'b0;
      decode_err   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (done_now) begin
               next_state = ST_DECODE;
               consume    = 1'b1;
            end else if (in_frame || accept_fall) begin
               next_state = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (done_now) begin
               next_state = ST_DECODE;
               consume    = 1'b1;
            end
         end
         ST_DECODE: begin
            if (!frame_ok) begin
               decode_err = 1'b1;
               next_state = ST_IDLE;
            end else if (is_conf) begin
               commit_conf = 1'b1;
               if (needs_quiet(conf_word[8:6], shift_reg[8:6])) begin
                  enter_quiet = 1'b1;
                  next_state  = ST_QUIET;
               end else begin
                  apply_now  = 1'b1;
                  next_state = ST_APPLY;
               end
            end else begin
               commit_trace = 1'b1;
               apply_now    = 1'b1;
               next_state   = ST_APPLY;
            end
         end
         ST_QUIET: begin
            if (qcnt == QW'(QUIET_CYCLES - 1)) begin
               apply_now  = 1'b1;
               next_state = ST_APPLY;
            end
         end
         ST_APPLY: begin
            if (done_now) begin
               next_state = ST_DECODE;
               consume    = 1'b1;
            end else if (in_frame || accept_fall) begin
               next_state = ST_SHIFT;
            end else begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Frame capture: shift register, saturating bit counter, in-frame and pending flags.
   always_ff @(posedge ck_1356meg) begin
      if (reset) begin
         shift_reg <= '0;
         count     <= '0;
         in_frame  <= 1'b0;
         pending   <= 1'b0;
      end else begin
         if (accept_fall) begin
            shift_reg <= '0;
            count     <= '0;
         end else if (in_frame && spck_rise && !ncs_q) begin
            shift_reg <= {shift_reg[14:0], mosi_q};
            if (count != 5'd31) count <= count + 5'd1;
         end
         in_frame <= in_frame_next;
         pending  <= pending_next;
      end
   end

   // Committed configuration, effective major mode, quiet timer and status pulses.
   always_ff @(posedge ck_1356meg) begin
      if (reset) begin
         conf_word    <= FPGA_CONF_WORD_RESET;
         major_mode   <= FPGA_MAJOR_MODE_OFF;
         trace_enable <= 1'b0;
         cfg_strobe   <= 1'b0;
         frame_err    <= 1'b0;
         busy         <= 1'b0;
         qcnt         <= '0;
      end else begin
         cfg_strobe <= apply_now;
         frame_err  <= decode_err | reject_fall;
         busy       <= busy_next;
         if (commit_conf)  conf_word    <= shift_reg[8:0];
         if (commit_trace) trace_enable <= shift_reg[0];
         if (enter_quiet) begin
            major_mode <= FPGA_MAJOR_MODE_OFF;
         end else if (apply_now) begin
            major_mode <= commit_conf ? shift_reg[8:6] : conf_word[8:6];
         end
         if (enter_quiet)             qcnt <= '0;
         else if (state == ST_QUIET)  qcnt <= qcnt + QW'(1);
      end
   end

endmodule

// File: tb/tb_hf_cmd_rx.sv
// tb/tb_hf_cmd_rx.sv - randomized self-checking bench for hf_cmd_rx
module tb_hf_cmd_rx;

   localparam int SYNC  = 2;
   localparam int QUIET = 16;
   localparam int WIN   = 60;

   logic       ck_1356meg = 1'b0;
   logic       reset, spck, mosi, ncs;
   logic [8:0] conf_word;
   logic [2:0] major_mode;
   logic [3:0] minor_mode;
   logic [1:0] subcarrier_frequency;
   logic       trace_enable, cfg_strobe, frame_err, busy;

   int n_checks = 0;
   int n_pass   = 0;
   int strobe_total = 0;
   int err_total    = 0;

   // Reference model: architectural state as seen by the ARM.
   logic [8:0] m_conf  = 9'h1C0;
   logic       m_trace = 1'b0;

   int         obs_strobes, obs_errs, obs_strobe_at, obs_off;
   logic [3:0] obs_minor;
   logic       obs_busy_mid, obs_busy_end;

   hf_cmd_rx #(.SYNC_STAGES(SYNC), .QUIET_CYCLES(QUIET), .FRAME_BITS(16)) dut (
      .ck_1356meg(ck_1356meg), .reset(reset), .spck(spck), .mosi(mosi), .ncs(ncs),
      .conf_word(conf_word), .major_mode(major_mode), .minor_mode(minor_mode),
      .subcarrier_frequency(subcarrier_frequency), .trace_enable(trace_enable),
      .cfg_strobe(cfg_strobe), .frame_err(frame_err), .busy(busy)
   );

   always #5 ck_1356meg = ~ck_1356meg;

   always @(negedge ck_1356meg) begin
      if (cfg_strobe === 1'b1) strobe_total++;
      if (frame_err === 1'b1)  err_total++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge ck_1356meg);
   endtask

   task automatic start_frame();
      ncs = 1'b0;
      tick(4);
   endtask

   task automatic shift_bits(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = bits[i];
         tick(3);
         spck = 1'b1;
         tick(4);
         spck = 1'b0;
         tick(1);
      end
   endtask

   task automatic end_frame();
      tick(3);
      ncs = 1'b1;
   endtask

   // Watches a fixed window after ncs rises; k counts negedges since the rise.
   task automatic observe();
      obs_strobes = 0; obs_errs = 0; obs_strobe_at = -1; obs_off = 0; obs_minor = 'x;
      for (int k = 1; k <= WIN; k++) begin
         tick(1);
         if (cfg_strobe === 1'b1) begin
            if (obs_strobes == 0) obs_strobe_at = k;
            obs_strobes++;
         end
         if (frame_err === 1'b1) obs_errs++;
         if (obs_strobes == 0 && major_mode === 3'd7) obs_off++;
         if (k == SYNC + 2) obs_minor = minor_mode;
      end
      obs_busy_end = busy;
   endtask

   task automatic run_frame(input logic [31:0] bits, input int n);
      start_frame();
      shift_bits(bits, n);
      obs_busy_mid = busy;
      end_frame();
      observe();
   endtask

   task automatic model_frame(input logic [31:0] bits, input int n, output logic err, output logic quiet);
      logic [3:0] cmd;
      logic [8:0] w;
      cmd = bits[15:12];
      w   = bits[8:0];
      err = 1'b0; quiet = 1'b0;
      if (n != 16) err = 1'b1;
      else if (cmd == 4'h1) begin
         quiet  = (w[8:6] != m_conf[8:6]) && (w[8:6] != 3'd7) && (m_conf[8:6] != 3'd7);
         m_conf = w;
      end else if (cmd == 4'h2) m_trace = bits[0];
      else err = 1'b1;
   endtask

   task automatic model_reset();
      m_conf = 9'h1C0; m_trace = 1'b0;
   endtask

   task automatic test_reset();
      int s0, e0;
      reset = 1'b1; spck = 1'b0; mosi = 1'b0; ncs = 1'b1;
      tick(6);
      reset = 1'b0;
      model_reset();
      s0 = strobe_total; e0 = err_total;
      tick(10);
      n_checks++; if (conf_word !== m_conf) $display("FAIL reset_conf: got %h expected %h", conf_word, m_conf); else n_pass++;
      n_checks++; if (major_mode !== 3'd7) $display("FAIL reset_major: got %0d expected 7", major_mode); else n_pass++;
      n_checks++; if (trace_enable !== 1'b0) $display("FAIL reset_trace: got %b expected 0", trace_enable); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if (strobe_total - s0 != 0 || err_total - e0 != 0)
         $display("FAIL reset_pulses: got strobes %0d errs %0d expected 0 0", strobe_total - s0, err_total - e0); else n_pass++;
   endtask

   task automatic test_conf_no_gap();
      logic err, quiet;
      model_frame(32'h1045, 16, err, quiet);
      run_frame(32'h1045, 16);
      n_checks++; if (obs_busy_mid !== 1'b1) $display("FAIL nogap_busy_mid: got %b expected 1", obs_busy_mid); else n_pass++;
      n_checks++; if (obs_strobes != 1) $display("FAIL nogap_strobes: got %0d expected 1", obs_strobes); else n_pass++;
      n_checks++; if (obs_strobe_at != SYNC + 2) $display("FAIL nogap_latency: got %0d expected %0d", obs_strobe_at, SYNC + 2); else n_pass++;
      n_checks++; if (conf_word !== m_conf) $display("FAIL nogap_conf: got %h expected %h", conf_word, m_conf); else n_pass++;
      n_checks++; if (major_mode !== 3'd1) $display("FAIL nogap_major: got %0d expected 1", major_mode); else n_pass++;
      n_checks++; if (minor_mode !== 4'd5) $display("FAIL nogap_minor: got %0d expected 5", minor_mode); else n_pass++;
      n_checks++; if (obs_busy_end !== 1'b0) $display("FAIL nogap_busy_end: got %b expected 0", obs_busy_end); else n_pass++;
   endtask

   task automatic test_conf_gap();
      logic err, quiet;
      model_frame(32'h1083, 16, err, quiet);
      run_frame(32'h1083, 16);
      n_checks++; if (obs_off != QUIET) $display("FAIL gap_off_cycles: got %0d expected %0d", obs_off, QUIET); else n_pass++;
      n_checks++; if (obs_minor !== 4'd3) $display("FAIL gap_minor_at_start: got %0d expected 3", obs_minor); else n_pass++;
      n_checks++; if (obs_strobes != 1) $display("FAIL gap_strobes: got %0d expected 1", obs_strobes); else n_pass++;
      n_checks++; if (obs_strobe_at != SYNC + 2 + QUIET)
         $display("FAIL gap_latency: got %0d expected %0d", obs_strobe_at, SYNC + 2 + QUIET); else n_pass++;
      n_checks++; if (major_mode !== 3'd2) $display("FAIL gap_major: got %0d expected 2", major_mode); else n_pass++;
      n_checks++; if (conf_word !== m_conf) $display("FAIL gap_conf: got %h expected %h", conf_word, m_conf); else n_pass++;
   endtask

   task automatic test_trace();
      logic err, quiet;
      for (int v = 1; v >= 0; v--) begin
         model_frame(32'h2000 | 32'(v), 16, err, quiet);
         run_frame(32'h2000 | 32'(v), 16);
         n_checks++; if (trace_enable !== m_trace) $display("FAIL trace_value: got %b expected %b", trace_enable, m_trace); else n_pass++;
         n_checks++; if (conf_word !== m_conf) $display("FAIL trace_conf: got %h expected %h", conf_word, m_conf); else n_pass++;
         n_checks++; if (obs_strobes != 1 || obs_strobe_at != SYNC + 2)
            $display("FAIL trace_strobe: got %0d at %0d expected 1 at %0d", obs_strobes, obs_strobe_at, SYNC + 2); else n_pass++;
      end
   endtask

   task automatic test_bad_frames();
      logic [31:0] bits [3];
      int          lens [3];
      logic        err, quiet;
      bits[0] = 32'h0822; lens[0] = 15;
      bits[1] = 32'h10FF; lens[1] = 17;
      bits[2] = 32'h7045; lens[2] = 16;
      for (int i = 0; i < 3; i++) begin
         model_frame(bits[i], lens[i], err, quiet);
         run_frame(bits[i], lens[i]);
         n_checks++; if (obs_errs != 1 || obs_strobes != 0)
            $display("FAIL bad_frame%0d_pulses: got err %0d strobe %0d expected 1 0", i, obs_errs, obs_strobes); else n_pass++;
         n_checks++; if (conf_word !== m_conf || trace_enable !== m_trace)
            $display("FAIL bad_frame%0d_state: got %h/%b expected %h/%b", i, conf_word, trace_enable, m_conf, m_trace); else n_pass++;
         n_checks++; if (obs_busy_end !== 1'b0) $display("FAIL bad_frame%0d_busy: got %b expected 0", i, obs_busy_end); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic err, quiet;
      int   s0, e0;
      model_frame(32'h2001, 16, err, quiet);
      run_frame(32'h2001, 16);
      // Reset in the middle of shifting a frame.
      start_frame();
      shift_bits(32'h11, 8);
      reset = 1'b1; tick(1); model_reset();
      n_checks++; if (conf_word !== m_conf || major_mode !== 3'd7 || trace_enable !== 1'b0 || busy !== 1'b0 ||
                      cfg_strobe !== 1'b0 || frame_err !== 1'b0)
         $display("FAIL reset_shift: got %h %0d %b %b %b %b expected 1c0 7 0 0 0 0",
                  conf_word, major_mode, trace_enable, busy, cfg_strobe, frame_err); else n_pass++;
      reset = 1'b0;
      s0 = strobe_total; e0 = err_total;
      shift_bits(32'h83, 8);
      end_frame();
      tick(40);
      n_checks++; if (strobe_total != s0 || err_total != e0)
         $display("FAIL reset_shift_orphan: got strobes %0d errs %0d expected 0 0", strobe_total - s0, err_total - e0); else n_pass++;
      model_frame(32'h1045, 16, err, quiet);
      run_frame(32'h1045, 16);
      n_checks++; if (conf_word !== m_conf || obs_strobes != 1)
         $display("FAIL reset_shift_after: got %h strobes %0d expected %h 1", conf_word, obs_strobes, m_conf); else n_pass++;
      // Reset in the middle of a quiet gap (mode 1 -> mode 2).
      start_frame();
      shift_bits(32'h1083, 16);
      end_frame();
      tick(SYNC + 6);
      n_checks++; if (major_mode !== 3'd7) $display("FAIL quiet_before_reset: got %0d expected 7", major_mode); else n_pass++;
      reset = 1'b1; tick(1); model_reset();
      n_checks++; if (conf_word !== m_conf || major_mode !== 3'd7 || trace_enable !== 1'b0 || busy !== 1'b0 || cfg_strobe !== 1'b0)
         $display("FAIL reset_quiet: got %h %0d %b %b %b expected 1c0 7 0 0 0",
                  conf_word, major_mode, trace_enable, busy, cfg_strobe); else n_pass++;
      reset = 1'b0;
      s0 = strobe_total;
      tick(30);
      n_checks++; if (strobe_total != s0) $display("FAIL reset_quiet_no_strobe: got %0d expected 0", strobe_total - s0); else n_pass++;
      model_frame(32'h1183, 16, err, quiet);
      run_frame(32'h1183, 16);
      n_checks++; if (conf_word !== m_conf || major_mode !== 3'd6 || obs_strobe_at != SYNC + 2)
         $display("FAIL reset_quiet_after: got %h %0d at %0d expected %h 6 at %0d",
                  conf_word, major_mode, obs_strobe_at, m_conf, SYNC + 2); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic err, quiet;
      int   s0, e0;
      s0 = strobe_total; e0 = err_total;
      model_frame(32'h1045, 16, err, quiet);
      model_frame(32'h2001, 16, err, quiet);
      start_frame();
      shift_bits(32'h1045, 16);
      end_frame();
      tick(2);
      start_frame();
      shift_bits(32'h2001, 16);
      end_frame();
      tick(WIN);
      n_checks++; if (strobe_total - s0 != 2 || err_total != e0)
         $display("FAIL b2b_pulses: got strobes %0d errs %0d expected 2 0", strobe_total - s0, err_total - e0); else n_pass++;
      n_checks++; if (conf_word !== m_conf || trace_enable !== m_trace || major_mode !== m_conf[8:6])
         $display("FAIL b2b_state: got %h %b %0d expected %h %b %0d",
                  conf_word, trace_enable, major_mode, m_conf, m_trace, m_conf[8:6]); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL b2b_busy: got %b expected 0", busy); else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] bits;
      int          n, r;
      logic [2:0]  old_mode;
      logic        err, quiet;
      int          exp_at, exp_off;
      for (int f = 0; f < 24; f++) begin
         r    = int'($urandom_range(0, 9));
         n    = 16;
         bits = $urandom & 32'h0FFF;
         if (r == 0) n = 15;
         else if (r == 1) n = 17;
         else if (r == 2) bits[15:12] = (4'($urandom_range(3, 15)) == 4'd3) ? 4'h0 : 4'($urandom_range(3, 15));
         else if (r <= 4) bits[15:12] = 4'h2;
         else bits[15:12] = 4'h1;
         old_mode = m_conf[8:6];
         model_frame(bits, n, err, quiet);
         run_frame(bits, n);
         n_checks++; if (obs_errs != int'(err) || obs_strobes != int'(!err))
            $display("FAIL rand%0d_pulses: got err %0d strobe %0d expected %0d %0d (bits %h n %0d)",
                     f, obs_errs, obs_strobes, err, !err, bits, n); else n_pass++;
         n_checks++; if (conf_word !== m_conf || trace_enable !== m_trace)
            $display("FAIL rand%0d_state: got %h/%b expected %h/%b", f, conf_word, trace_enable, m_conf, m_trace); else n_pass++;
         n_checks++; if (major_mode !== m_conf[8:6]) $display("FAIL rand%0d_major: got %0d expected %0d", f, major_mode, m_conf[8:6]); else n_pass++;
         n_checks++; if (obs_busy_end !== 1'b0) $display("FAIL rand%0d_busy: got %b expected 0", f, obs_busy_end); else n_pass++;
         if (!err) begin
            exp_at  = SYNC + 2 + (quiet ? QUIET : 0);
            exp_off = quiet ? QUIET : ((old_mode == 3'd7) ? SYNC + 1 : 0);
            n_checks++; if (obs_strobe_at != exp_at) $display("FAIL rand%0d_latency: got %0d expected %0d", f, obs_strobe_at, exp_at); else n_pass++;
            n_checks++; if (obs_off != exp_off) $display("FAIL rand%0d_off_cycles: got %0d expected %0d", f, obs_off, exp_off); else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_conf_no_gap();
      test_conf_gap();
      test_trace();
      test_bad_frames();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
